// File: rtl/riscv_rob_multi_pkg.sv
// riscv_rob_multi_pkg: shared entry layout and helpers for the multi-way reorder buffer control.
package riscv_rob_multi_pkg;
  localparam int REG_W = 5;
  typedef struct packed {
    logic             valid;
    logic             pending;
    logic             wen;
    logic [REG_W-1:0] waddr;
  } rob_entry_t;
  function automatic int unsigned popc(input logic [31:0] v);
    popc = 0;
    for (int i = 0; i < 32; i++) popc += 32'(v[i]);
  endfunction
endpackage

// File: rtl/riscv_rob_multi_youngest.sv
// riscv_rob_multi_youngest: finds the youngest matching slot, scanning oldest-to-youngest from head.
module riscv_rob_multi_youngest #(
  parameter int DEPTH = 16,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_match,
  input  logic [SW-1:0]    i_head,
  output logic             o_hit,
  output logic [SW-1:0]    o_slot
);
  always_comb begin
    o_hit  = |i_match;
    o_slot = '0;
    for (int k = 0; k < DEPTH; k++)
      if (i_match[i_head + SW'(k)]) o_slot = i_head + SW'(k);
  end
endmodule

// File: rtl/riscv_rob_multi.sv
// riscv_rob_multi: N-way reorder buffer control with in-order multi-commit, full flush
// and register lookup ports feeding the bypass select.
module riscv_rob_multi
  import riscv_rob_multi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WAYS  = 2,
  parameter int NQ    = 4,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [WAYS-1:0]       i_alloc_val,
  input  logic [WAYS-1:0]       i_alloc_wen,
  input  logic [WAYS*REG_W-1:0] i_alloc_waddr,
  output logic                  o_alloc_rdy,
  output logic [WAYS*SW-1:0]    o_alloc_slot,
  input  logic [WAYS-1:0]       i_fill_val,
  input  logic [WAYS*SW-1:0]    i_fill_slot,
  output logic [WAYS-1:0]       o_commit_val,
  output logic [WAYS-1:0]       o_commit_wen,
  output logic [WAYS*SW-1:0]    o_commit_slot,
  output logic [WAYS*REG_W-1:0] o_commit_waddr,
  input  logic                  i_flush,
  input  logic [NQ*REG_W-1:0]   i_q_raddr,
  output logic [NQ-1:0]         o_q_hit,
  output logic [NQ*SW-1:0]      o_q_slot,
  output logic [NQ-1:0]         o_q_filled,
  output logic [SW:0]           o_count,
  output logic                  o_empty
);
  rob_entry_t      r_ent [DEPTH];
  logic [SW:0]     r_head, r_tail;
  logic [SW:0]     w_count, w_nalloc, w_ncommit;
  logic            w_alloc_ok;
  logic [WAYS-1:0] w_ok;
  assign w_count     = r_tail - r_head;
  assign o_count     = w_count;
  assign o_empty     = w_count == '0;
  // Space check uses registered count only: this cycle's commits do not free slots.
  assign o_alloc_rdy = w_count <= (SW+1)'(DEPTH - WAYS);
  assign w_alloc_ok  = o_alloc_rdy & !i_flush & ((i_alloc_val & (i_alloc_val + WAYS'(1))) == '0);
  assign w_nalloc    = w_alloc_ok ? (SW+1)'(popc(32'(i_alloc_val))) : '0;
  assign w_ncommit   = (SW+1)'(popc(32'(o_commit_val)));
  for (genvar i = 0; i < WAYS; i++) begin : g_way
    logic [SW-1:0] w_cs;
    assign w_cs = r_head[SW-1:0] + SW'(i);
    assign w_ok[i] = r_ent[w_cs].valid & !r_ent[w_cs].pending;
    assign o_commit_slot[i*SW +: SW] = w_cs;
    assign o_commit_wen[i] = o_commit_val[i] & r_ent[w_cs].wen;
    assign o_commit_waddr[i*REG_W +: REG_W] = r_ent[w_cs].waddr;
    assign o_alloc_slot[i*SW +: SW] = r_tail[SW-1:0] + SW'(i);
  end
  always_comb begin
    logic run;
    run = !i_flush;
    o_commit_val = '0;
    for (int i = 0; i < WAYS; i++) begin
      run = run & w_ok[i];
      o_commit_val[i] = run;
    end
  end
  for (genvar q = 0; q < NQ; q++) begin : g_q
    logic [DEPTH-1:0] w_match;
    logic [SW-1:0]    w_slot;
    logic             w_hit;
    for (genvar e = 0; e < DEPTH; e++) begin : g_e
      assign w_match[e] = r_ent[e].valid & r_ent[e].wen & (r_ent[e].waddr == i_q_raddr[q*REG_W +: REG_W])
                          & (i_q_raddr[q*REG_W +: REG_W] != '0);
    end
    riscv_rob_multi_youngest #(.DEPTH(DEPTH), .SW(SW)) u_young (
      .i_match(w_match),
      .i_head (r_head[SW-1:0]),
      .o_hit  (w_hit),
      .o_slot (w_slot)
    );
    assign o_q_hit[q] = w_hit;
    assign o_q_slot[q*SW +: SW] = w_slot;
    assign o_q_filled[q] = w_hit & !r_ent[w_slot].pending;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_head <= '0;
      r_tail <= '0;
      for (int e = 0; e < DEPTH; e++) r_ent[e] <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      for (int e = 0; e < DEPTH; e++) r_ent[e].valid <= 1'b0;
    end else begin
      for (int i = 0; i < WAYS; i++)
        if (o_commit_val[i]) r_ent[r_head[SW-1:0] + SW'(i)].valid <= 1'b0;
      for (int i = 0; i < WAYS; i++)
        if (i_fill_val[i] && r_ent[i_fill_slot[i*SW +: SW]].valid)
          r_ent[i_fill_slot[i*SW +: SW]].pending <= 1'b0;
      // Alloc targets only free slots, so it never collides with commit or a valid fill.
      for (int i = 0; i < WAYS; i++)
        if (w_alloc_ok && i_alloc_val[i])
          r_ent[r_tail[SW-1:0] + SW'(i)] <= '{1'b1, 1'b1, i_alloc_wen[i], i_alloc_waddr[i*REG_W +: REG_W]};
      r_head <= r_head + w_ncommit;
      r_tail <= r_tail + w_nalloc;
    end
  a_contig: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_alloc_val & (i_alloc_val + WAYS'(1))) == '0);
endmodule

// File: tb/tb_riscv_rob_multi.sv
// tb_riscv_rob_multi: randomized and directed checks of riscv_rob_multi against a queue-based model.
module tb_riscv_rob_multi;
  localparam int DEPTH = 16, WAYS = 2, NQ = 4, SW = 4;
  logic clk = 0, reset = 1;
  logic [WAYS-1:0] alloc_val, alloc_wen, fill_val, commit_val, commit_wen;
  logic [WAYS*5-1:0] alloc_waddr, commit_waddr;
  logic [WAYS*SW-1:0] alloc_slot, fill_slot, commit_slot;
  logic alloc_rdy, flush, empty;
  logic [NQ*5-1:0] q_raddr;
  logic [NQ-1:0] q_hit, q_filled;
  logic [NQ*SW-1:0] q_slot;
  logic [SW:0] count;
  always #5 clk = ~clk;
  riscv_rob_multi #(.DEPTH(DEPTH), .WAYS(WAYS), .NQ(NQ)) dut (
    .i_clk(clk), .i_reset(reset), .i_alloc_val(alloc_val), .i_alloc_wen(alloc_wen),
    .i_alloc_waddr(alloc_waddr), .o_alloc_rdy(alloc_rdy), .o_alloc_slot(alloc_slot),
    .i_fill_val(fill_val), .i_fill_slot(fill_slot), .o_commit_val(commit_val),
    .o_commit_wen(commit_wen), .o_commit_slot(commit_slot), .o_commit_waddr(commit_waddr),
    .i_flush(flush), .i_q_raddr(q_raddr), .o_q_hit(q_hit), .o_q_slot(q_slot),
    .o_q_filled(q_filled), .o_count(count), .o_empty(empty));
  typedef struct {int slot; bit pend; bit wen; int waddr;} ment_t;
  ment_t mq[$];
  int m_tail = 0;
  int n_chk = 0, n_pass = 0;
  logic [WAYS-1:0] n_av, n_wen, n_fv;
  int n_wa[WAYS], n_fs[WAYS], n_qa[NQ];
  logic n_flush;
  int e_nc;
  bit e_rdy;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask
  task automatic idle();
    n_av = 0; n_wen = 0; n_fv = 0; n_flush = 0;
    for (int i = 0; i < WAYS; i++) begin n_wa[i] = 0; n_fs[i] = 0; end
    for (int q = 0; q < NQ; q++) n_qa[q] = 0;
  endtask
  task automatic drive();
    int sz, f;
    logic [WAYS-1:0] cv, cw;
    @(negedge clk);
    alloc_val = n_av; alloc_wen = n_wen; fill_val = n_fv; flush = n_flush;
    for (int i = 0; i < WAYS; i++) begin
      alloc_waddr[i*5 +: 5] = 5'(n_wa[i]);
      fill_slot[i*SW +: SW] = SW'(n_fs[i]);
    end
    for (int q = 0; q < NQ; q++) q_raddr[q*5 +: 5] = 5'(n_qa[q]);
    #1;
    sz = mq.size();
    e_rdy = (DEPTH - sz) >= WAYS;
    chk("count", 32'(count), sz);
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("alloc_rdy", 32'(alloc_rdy), 32'(e_rdy));
    if (e_rdy)
      for (int i = 0; i < WAYS; i++) chk("alloc_slot", 32'(alloc_slot[i*SW +: SW]), (m_tail + i) % DEPTH);
    e_nc = 0;
    if (!n_flush) while (e_nc < WAYS && e_nc < sz && !mq[e_nc].pend) e_nc++;
    cv = 0; cw = 0;
    for (int i = 0; i < e_nc; i++) begin
      cv[i] = 1; cw[i] = mq[i].wen;
      chk("commit_slot", 32'(commit_slot[i*SW +: SW]), mq[i].slot);
      chk("commit_waddr", 32'(commit_waddr[i*5 +: 5]), mq[i].waddr);
    end
    chk("commit_val", 32'(commit_val), 32'(cv));
    chk("commit_wen", 32'(commit_wen), 32'(cw));
    for (int q = 0; q < NQ; q++) begin
      f = -1;
      if (n_qa[q] != 0)
        for (int j = sz - 1; j >= 0; j--)
          if (mq[j].wen && mq[j].waddr == n_qa[q]) begin f = j; break; end
      chk("q_hit", 32'(q_hit[q]), 32'(f >= 0));
      if (f >= 0) begin
        chk("q_slot", 32'(q_slot[q*SW +: SW]), mq[f].slot);
        chk("q_filled", 32'(q_filled[q]), 32'(!mq[f].pend));
      end
    end
  endtask
  task automatic clock();
    @(posedge clk);
    if (n_flush) begin
      mq.delete(); m_tail = 0;
    end else begin
      repeat (e_nc) void'(mq.pop_front());
      for (int i = 0; i < WAYS; i++)
        if (n_fv[i]) foreach (mq[j]) if (mq[j].slot == n_fs[i]) mq[j].pend = 0;
      if (e_rdy)
        for (int i = 0; i < WAYS; i++)
          if (n_av[i]) begin
            mq.push_back('{m_tail, 1'b1, n_wen[i], n_wa[i]});
            m_tail = (m_tail + 1) % DEPTH;
          end
    end
  endtask
  task automatic cyc();
    drive(); clock();
  endtask
  task automatic alloc2(input int a, input int b);
    idle(); n_av = 2'b11; n_wen = 2'b11; n_wa[0] = a; n_wa[1] = b;
  endtask
  initial begin
    int r;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    // reset state, then alloc r1,r2
    drive();
    chk("rst_rdy", 32'(alloc_rdy), 1); chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0); chk("rst_cv", 32'(commit_val), 0); chk("rst_hit", 32'(q_hit), 0);
    clock();
    alloc2(1, 2); n_qa[0] = 1;
    drive(); chk("a01_slots", 32'(alloc_slot), 32'h10); clock();
    idle(); n_qa[0] = 1; n_fv = 2'b01; n_fs[0] = 1;
    drive();
    chk("t1_count", 32'(count), 2); chk("t1_hit", 32'(q_hit[0]), 1);
    chk("t1_slot", 32'(q_slot[3:0]), 0); chk("t1_filled", 32'(q_filled[0]), 0);
    clock();
    idle(); n_fv = 2'b01; n_fs[0] = 0;
    drive(); chk("t2_nocommit", 32'(commit_val), 0); clock();
    idle();
    drive(); chk("t2_commit", 32'(commit_val), 3); chk("t2_waddr", 32'(commit_waddr), {22'd0, 5'd2, 5'd1}); clock();
    drive(); chk("t2_empty", 32'(empty), 1); clock();
    // youngest-producer lookup
    alloc2(7, 5); cyc();
    idle(); n_av = 2'b01; n_wen = 2'b01; n_wa[0] = 5; cyc();
    idle(); n_qa[0] = 5; n_fv = 2'b11; n_fs[0] = 2; n_fs[1] = 3;
    drive(); chk("t4_slot", 32'(q_slot[3:0]), 4); clock();
    idle(); n_qa[0] = 5;
    drive(); chk("t4_cv", 32'(commit_val), 3); clock();
    idle(); n_qa[0] = 5; n_qa[1] = 0; n_fv = 2'b01; n_fs[0] = 4;
    drive(); chk("t4_still", 32'(q_slot[3:0]), 4); chk("t4_r0", 32'(q_hit[1]), 0); clock();
    idle();
    drive(); chk("t4_c4", 32'(commit_slot[3:0]), 4); clock();
    // fill to full with head pending, then drain across the wrap
    for (int k = 0; k < 8; k++) begin alloc2(10 + k, 20 + k); cyc(); end
    for (int k = 1; k <= 15; k += 2) begin
      idle(); n_fv = (k < 15) ? 2'b11 : 2'b01; n_fs[0] = (5 + k) % DEPTH; n_fs[1] = (6 + k) % DEPTH;
      drive(); chk("t3_full_rdy", 32'(alloc_rdy), 0); chk("t3_cnt", 32'(count), 16); clock();
    end
    idle(); n_fv = 2'b01; n_fs[0] = 5;
    drive(); chk("t3_blocked", 32'(commit_val), 0); clock();
    idle();
    drive(); chk("t3_first", 32'(commit_slot), 32'h65); clock();
    repeat (8) cyc();
    drive(); chk("t3_empty", 32'(empty), 1); clock();
    // flush beats same-cycle commit, alloc and fill
    alloc2(1, 2); cyc();
    idle(); n_fv = 2'b11; n_fs[0] = 5; n_fs[1] = 6; cyc();
    alloc2(3, 4); n_fv = 2'b01; n_fs[0] = 5; n_flush = 1;
    drive(); chk("t5_cv", 32'(commit_val), 0); clock();
    idle();
    drive(); chk("t5_cnt", 32'(count), 0); chk("t5_tail", 32'(alloc_slot), 32'h10); clock();
    // async reset mid-stream
    for (int k = 0; k < 3; k++) begin alloc2(3, 6); cyc(); end
    idle(); n_av = 2'b01; n_wen = 2'b01; n_wa[0] = 3; cyc();
    idle(); n_qa[0] = 3;
    drive(); chk("t6_cnt7", 32'(count), 7);
    reset = 1; #1;
    chk("t6_cnt", 32'(count), 0); chk("t6_rdy", 32'(alloc_rdy), 1); chk("t6_empty", 32'(empty), 1);
    chk("t6_cv", 32'(commit_val), 0); chk("t6_hit", 32'(q_hit), 0);
    mq.delete(); m_tail = 0;
    @(posedge clk); @(negedge clk) reset = 0;
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      idle();
      r = $urandom_range(0, 3);
      n_av = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      n_wen = 2'($urandom);
      for (int i = 0; i < WAYS; i++) begin
        n_wa[i] = $urandom_range(0, 7);
        n_fv[i] = ((c % 1000) < 300) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
        n_fs[i] = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? mq[$urandom_range(0, mq.size() - 1)].slot
                                                                : $urandom_range(0, DEPTH - 1);
      end
      n_flush = $urandom_range(0, 79) == 0;
      for (int q = 0; q < NQ; q++) n_qa[q] = $urandom_range(0, 7);
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
